fibonacci: RTL and testbench
============================

# fibonacci

Registered Fibonacci lookup block. Each rising clock edge it samples an 8-bit index `num` and presents F(num) on a 32-bit output one cycle later, with F(0)=0 and F(1)=1. It is a standalone arithmetic utility used by test and demo datapaths that need Fibonacci values at full throughput, one new index per cycle. Every index whose value does not fit in 32 bits returns a saturation code.

## Interface
- Parameters: none. Widths are fixed: 8-bit index, 32-bit result.
- `clk`  input  1  Single system clock. All state updates on the rising edge.
- `rst_n`  input  1  Reset: asynchronous, active-low.
- `num`  input  8  Fibonacci index, unsigned. Sampled on every rising edge of `clk`.
- `fib`  output  32  Registered result F(num), unsigned.
- Declaration order is `num`, `clk`, `fib`, `rst_n`. Existing positional instantiations of the form (num, clk, fib) therefore keep their mapping, and `rst_n` is appended last.

## Operation
- Valid range is 0 ≤ num ≤ 47. F(47) = 2971215073 (0xB11924E1) is the largest Fibonacci value that fits in 32 bits unsigned.
- The block defines the sequence as F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).
- Implementation is a 48-entry constant table, either a ROM or a case statement, indexed by `num`, followed by a 32-bit output register.
- No iterative computation is permitted, because full throughput is required.
- Out of range, num ≥ 48: `fib` loads 32'hFFFF_FFFF as a saturation code. This value is never a legal Fibonacci result within the valid range.
- The table index uses all 8 bits of `num`. No truncation or aliasing is allowed, so for example num=64 must not return F(0).
- No handshake is used. `num` is a plain level input, and every clock edge produces a new result.

## Timing
- Latency is exactly 1 cycle. At the rising edge where `num` = n is sampled, `fib` becomes F(n) and holds until the next edge.
- Throughput is one index per cycle. Back-to-back changes of `num` on every cycle each produce their own result.
- Reset value: `fib` = 0.
  - Assertion of `rst_n` (low) clears `fib` immediately, without waiting for a clock edge.
  - `fib` holds 0 for as long as `rst_n` is low.
- Reset release: the first rising edge of `clk` with `rst_n` high loads F(num).
- Reset asserted mid-stream: any in-flight result is discarded, and no stale value reappears after release.
- Combinational path from `num` to the register is table decode only. `fib` is driven directly from flops with no output logic.

## Test plan
- Reset: hold `rst_n`=0 with num=10, then pulse `clk` → `fib` = 0 throughout. Release reset, one edge later → `fib` = 55.
- Sequential sweep: drive num = 0,1,2,…,47, one value per cycle → one cycle after each value, `fib` = 0, 1, 1, 2, 3, 5, …, 1836311903 (F46), 2971215073 (F47), each matching the golden table.
- Boundary: drive num=46, then 47, then 48 → `fib` = 1836311903, then 0xB11924E1, then 0xFFFFFFFF.
- Out-of-range aliasing: drive num = 64, 128, 255 → `fib` = 0xFFFFFFFF for each, never 0 or any other table value.
- Random back-to-back: apply random `num` in 0–255 every cycle → `fib` at cycle t+1 equals the model value for `num` at cycle t, with no bubbles.
- Mid-operation reset: sweep num upward and drop `rst_n` asynchronously between clock edges at num=20 → `fib` goes to 0 immediately. After release, `fib` follows the current `num` with 1-cycle latency.

Source files
------------

// File: rtl/fibonacci.sv
// Registered Fibonacci lookup: F(num) from a constant table, one cycle of latency,
// saturating to all-ones for indices whose value does not fit in 32 bits.
module fibonacci (
    input  logic [7:0]  num,
    input  logic        clk,
    output logic [31:0] fib,
    input  logic        rst_n
);

    logic [31:0] table_value;

    // Full 8-bit decode; anything past F(47) falls to the saturation code.
    always_comb begin
        table_value = 32'hFFFF_FFFF;
        case (num)
            8'd0:  table_value = 32'd0;
            8'd1:  table_value = 32'd1;
            8'd2:  table_value = 32'd1;
            8'd3:  table_value = 32'd2;
            8'd4:  table_value = 32'd3;
            8'd5:  table_value = 32'd5;
            8'd6:  table_value = 32'd8;
            8'd7:  table_value = 32'd13;
            8'd8:  table_value = 32'd21;
            8'd9:  table_value = 32'd34;
            8'd10: table_value = 32'd55;
            8'd11: table_value = 32'd89;
            8'd12: table_value = 32'd144;
            8'd13: table_value = 32'd233;
            8'd14: table_value = 32'd377;
            8'd15: table_value = 32'd610;
            8'd16: table_value = 32'd987;
            8'd17: table_value = 32'd1597;
            8'd18: table_value = 32'd2584;
            8'd19: table_value = 32'd4181;
            8'd20: table_value = 32'd6765;
            8'd21: table_value = 32'd10946;
            8'd22: table_value = 32'd17711;
            8'd23: table_value = 32'd28657;
            8'd24: table_value = 32'd46368;
            8'd25: table_value = 32'd75025;
            8'd26: table_value = 32'd121393;
            8'd27: table_value = 32'd196418;
            8'd28: table_value = 32'd317811;
            8'd29: table_value = 32'd514229;
            8'd30: table_value = 32'd832040;
            8'd31: table_value = 32'd1346269;
            8'd32: table_value = 32'd2178309;
            8'd33: table_value = 32'd3524578;
            8'd34: table_value = 32'd5702887;
            8'd35: table_value = 32'd9227465;
            8'd36: table_value = 32'd14930352;
            8'd37: table_value = 32'd24157817;
            8'd38: table_value = 32'd39088169;
            8'd39: table_value = 32'd63245986;
            8'd40: table_value = 32'd102334155;
            8'd41: table_value = 32'd165580141;
            8'd42: table_value = 32'd267914296;
            8'd43: table_value = 32'd433494437;
            8'd44: table_value = 32'd701408733;
            8'd45: table_value = 32'd1134903170;
            8'd46: table_value = 32'd1836311903;
            8'd47: table_value = 32'd2971215073;
            default: table_value = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fib <= 32'd0;
        else
            fib <= table_value;
    end

endmodule

// File: tb/tb_fibonacci.sv
// Directed and random checks of the fibonacci lookup against an iterative model,
// with expected results queued at drive time and popped one edge later.
module tb_fibonacci;

    logic [7:0]  num;
    logic        clk;
    logic [31:0] fib;
    logic        rst_n;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    fibonacci dut (
        .num   (num),
        .clk   (clk),
        .fib   (fib),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input int n);
        longint a, b, t;
        if (n >= 48) return 32'hFFFF_FFFF;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] expected;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=<scoreboard empty>", tag, fib);
        end else begin
            expected = exp_q.pop_front();
            check(tag, fib, expected);
        end
    endtask

    // Drive on the falling edge, push the model value, check just after the rising edge.
    task automatic applyStimulus(input logic [7:0] n, input string tag);
        @(negedge clk);
        num = n;
        exp_q.push_back(model(int'(n)));
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s[num=%0d]", tag, n));
    endtask

    initial begin
        rst_n = 1'b1;
        num = 8'd10;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", fib, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", fib, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", fib, 32'd0);
        applyStimulus(8'd10, "reset_release");

        for (int i = 0; i <= 47; i++)
            applyStimulus(8'(i), "sweep");

        applyStimulus(8'd46, "boundary");
        applyStimulus(8'd47, "boundary");
        applyStimulus(8'd48, "boundary");

        applyStimulus(8'd64, "alias");
        applyStimulus(8'd128, "alias");
        applyStimulus(8'd255, "alias");
        applyStimulus(8'd0, "alias_back");

        for (int i = 0; i < 40; i++)
            applyStimulus(8'($urandom_range(0, 255)), "random");

        for (int i = 0; i < 20; i++)
            applyStimulus(8'(i), "mid_sweep");
        @(negedge clk);
        num = 8'd20;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", fib, 32'd0);
        @(posedge clk);
        #1;
        check("mid_reset_hold", fib, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_reset_no_stale", fib, 32'd0);
        applyStimulus(8'd21, "post_reset");
        applyStimulus(8'd22, "post_reset");
        applyStimulus(8'd47, "post_reset");

        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
